shift_exec_stage: RTL and testbench
===================================

Name: shift_exec_stage

Overview:
- Pipelined execute-stage wrapper around the 64-bit left barrel shifter (`barrel_shifter_left`: data, _shift, out).
- Accepts shift micro-ops from issue via valid/ready and decodes SLL/SRL/SRA plus 32-bit W variants.
- Masks shift amounts, implements right shifts by bit-reverse around the left shifter, and delivers a registered, sign-extended result to writeback.
- Two register stages with full backpressure.

Parameters:
- XLEN, 64, datapath width; only 64 supported.
- SHAMT_W, 6, shift-amount bits used for 64-bit ops; W ops use 5.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  issue presents an op.
- in_ready  output  1  stage can accept.
- in_op  input  3  000 SLL, 001 SRL, 010 SRA, 100 SLLW, 101 SRLW, 110 SRAW, 011/111 see Optional Feature.
- in_a  input  64  operand to shift.
- in_b  input  64  shift amount source; only low bits used.
- in_tag  input  5  destination register tag, passed through.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts.
- out_result  output  64  shifted result.
- out_tag  output  5  tag of out_result.
- out_illegal  output  1  op was unsupported; out_result = 0.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, out_illegal=0, in_ready=1 after release. Reset mid-operation drops all in-flight ops; nothing is replayed.
- Stage 1 (capture): on in_valid & in_ready, register op, a, tag, and masked shamt.
  - 64-bit ops: shamt = in_b[5:0].
  - W ops: shamt = {1'b0, in_b[4:0]}.
  - Upper bits of in_b are ignored; e.g. 65 → 1.
- Stage 1→2 (compute, combinational from s1 registers):
  - SLL/SLLW: shifter input = a.
  - SRL/SRA: input = bitrev(a), output = bitrev(shifter out).
  - SRA fill: bits [63:64-shamt] = a[63] when shamt>0.
  - W ops operate on a[31:0], placed in [31:0] with zero upper bits before shifting. For SRLW/SRAW the right shift is performed on the 32-bit value; SRAW fill bit = a[31].
  - Final W result = sign-extend of bit 31 of the 32-bit result.
  - shamt=0 returns the operand (W: sign-extended a[31:0]).
- Stage 2: result, tag, and illegal registered. out_* change only when out_valid=0 or out_ready=1.
- Handshake:
  - s2 advance = !s2_valid | out_ready.
  - s1 advance = s1_valid & s2 advance.
  - in_ready = !s1_valid | s1 advance.
  - Latency: 2 cycles from accept to out_valid with no stall.
  - Throughput: 1 op/cycle.
  - Holds two ops max; with out_ready=0, in_ready falls after the second accept.
  - A simultaneous accept and drain in the same cycle is legal and loses no op.
- out_valid, once high, stays high with stable data until out_ready=1.
- Illegal ops flow through the pipeline normally with out_illegal=1 and out_result=0.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: 011 = ROL, 111 = ROR, 64-bit, shamt = in_b[5:0].
  - ROL = (a<<s) | (a>>(64-s)), built from two shifter passes or an OR of reversed paths; s=0 returns a.
  - ROR is the mirror.
  - out_illegal=0 for these ops.
- Undefined: 011/111 are illegal (out_illegal=1, out_result=0); no extra logic is synthesised.

Test Plan:
- SLL a=0x1, b=13, out_ready=1 → out_result=0x0000_0000_0000_2000 two cycles after accept; b=65 → 0x2; b=63 → 0x8000_0000_0000_0000.
- SRA a=0x8000_0000_0000_0000, b=4 → 0xF800_0000_0000_0000; SRL with the same operands → 0x0800_0000_0000_0000.
- a=0xFFFF_FFFF_8000_0000, b=36 (masked to 4):
  - SRLW → 0x0000_0000_0800_0000.
  - SRAW → 0xFFFF_FFFF_F800_0000.
  - SLLW a=0x4000_0000, b=1 → 0xFFFF_FFFF_8000_0000.
- Backpressure: out_ready=0, issue three ops back-to-back → in_ready=0 after two accepts, out_result frozen on the first result; out_ready=1 → all three drain in order with tags intact.
- Reset: assert rst_n=0 while two ops are in flight → out_valid=0 immediately (async); after release, in_ready=1 and no stale result appears.
- op=111, a=0x1, b=1 → with SHIFT_ROTATE_EN: 0x8000_0000_0000_0000, out_illegal=0; without: result 0, out_illegal=1.

Source files
------------

// File: rtl/shift_exec_stage.sv
// Two-stage execute wrapper around a 64-bit left barrel shifter: SLL/SRL/SRA and W variants.
// Optional rotate ops (011 ROL, 111 ROR) are enabled by defining SHIFT_ROTATE_EN.

module barrel_shifter_left #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = 6
) (
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] _shift,
    output logic [XLEN-1:0]    out
);
    assign out = data << _shift;
endmodule

module shift_exec_stage #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_tag,
    output logic            out_illegal
);
    localparam int HALF = XLEN / 2;
    localparam logic [1:0] K_SLL = 2'b00;
    localparam logic [1:0] K_SRL = 2'b01;
    localparam logic [1:0] K_SRA = 2'b10;
    localparam logic [1:0] K_ROT = 2'b11;

    function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = x[XLEN-1-i];
        end
        return r;
    endfunction

    logic               s1_valid_r;
    logic [2:0]         s1_op_r;
    logic [XLEN-1:0]    s1_a_r;
    logic [4:0]         s1_tag_r;
    logic [SHAMT_W-1:0] s1_shamt_r;

    logic               s2_adv_s;
    logic               s1_adv_s;
    logic               accept_s;
    logic [SHAMT_W-1:0] shamt_in_s;
    logic               unused_b_s;

    logic [1:0]         kind_s;
    logic               w_op_s;
    logic               right_s;
    logic [XLEN-1:0]    a_ext_s;
    logic [XLEN-1:0]    sh_in_s;
    logic [XLEN-1:0]    sh_raw_s;
    logic [XLEN-1:0]    sh_out_s;
    logic [XLEN-1:0]    fill_s;
    logic [XLEN-1:0]    shifted_s;
    logic [XLEN-1:0]    res_s;
    logic               ill_s;

    assign s2_adv_s   = !out_valid || out_ready;
    assign s1_adv_s   = s1_valid_r && s2_adv_s;
    assign in_ready   = !s1_valid_r || s1_adv_s;
    assign accept_s   = in_valid && in_ready;
    assign unused_b_s = ^in_b[XLEN-1:SHAMT_W];

    // Shift-amount masking: 6 bits for 64-bit ops, 5 bits for W ops
    always_comb begin
`ifdef SHIFT_ROTATE_EN
        if (!in_op[2] || (in_op[1:0] == K_ROT)) begin
`else
        if (!in_op[2]) begin
`endif
            shamt_in_s = in_b[SHAMT_W-1:0];
        end else begin
            shamt_in_s = {1'b0, in_b[SHAMT_W-2:0]};
        end
    end

    // Stage 1 capture register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'd0;
            s1_a_r     <= {XLEN{1'b0}};
            s1_tag_r   <= 5'd0;
            s1_shamt_r <= {SHAMT_W{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= in_op;
            s1_a_r     <= in_a;
            s1_tag_r   <= in_tag;
            s1_shamt_r <= shamt_in_s;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    assign kind_s = s1_op_r[1:0];
    assign w_op_s = s1_op_r[2] && (kind_s != K_ROT);
`ifdef SHIFT_ROTATE_EN
    assign right_s = (kind_s == K_SRL) || (kind_s == K_SRA) || (s1_op_r == 3'b111);
`else
    assign right_s = (kind_s == K_SRL) || (kind_s == K_SRA);
`endif
    // W ops shift the zero-extended low word so right shifts never pull in upper bits
    assign a_ext_s  = w_op_s ? {{HALF{1'b0}}, s1_a_r[HALF-1:0]} : s1_a_r;
    assign sh_in_s  = right_s ? bitrev(a_ext_s) : a_ext_s;
    assign sh_out_s = right_s ? bitrev(sh_raw_s) : sh_raw_s;

    barrel_shifter_left #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shl (
        .data   (sh_in_s),
        ._shift (s1_shamt_r),
        .out    (sh_raw_s)
    );

`ifdef SHIFT_ROTATE_EN
    logic [XLEN-1:0]    rot_in_s;
    logic [XLEN-1:0]    rot_raw_s;
    logic [XLEN-1:0]    rot_q_s;
    logic [SHAMT_W-1:0] rot_amt_s;

    // Second pass shifts the other way by (XLEN - s) mod XLEN; s=0 yields a|a = a
    assign rot_in_s  = right_s ? s1_a_r : bitrev(s1_a_r);
    assign rot_amt_s = {SHAMT_W{1'b0}} - s1_shamt_r;
    assign rot_q_s   = right_s ? rot_raw_s : bitrev(rot_raw_s);

    barrel_shifter_left #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_rot (
        .data   (rot_in_s),
        ._shift (rot_amt_s),
        .out    (rot_raw_s)
    );
`endif

    // Arithmetic fill mask for the vacated upper bits of SRA/SRAW
    always_comb begin
        fill_s = {XLEN{1'b0}};
        if (w_op_s) begin
            if (s1_a_r[HALF-1]) begin
                fill_s = {{HALF{1'b0}}, ~({HALF{1'b1}} >> s1_shamt_r[SHAMT_W-2:0])};
            end else begin
                fill_s = {XLEN{1'b0}};
            end
        end else begin
            if (s1_a_r[XLEN-1]) begin
                fill_s = ~({XLEN{1'b1}} >> s1_shamt_r);
            end else begin
                fill_s = {XLEN{1'b0}};
            end
        end
    end

    // Result select, illegal decode and W sign extension
    always_comb begin
        shifted_s = {XLEN{1'b0}};
        ill_s     = 1'b0;
        case (kind_s)
            K_SLL, K_SRL: shifted_s = sh_out_s;
            K_SRA:        shifted_s = sh_out_s | fill_s;
`ifdef SHIFT_ROTATE_EN
            K_ROT:        shifted_s = sh_out_s | rot_q_s;
`else
            K_ROT:        ill_s = 1'b1;
`endif
            default:      ill_s = 1'b1;
        endcase
        if (ill_s) begin
            res_s = {XLEN{1'b0}};
        end else if (w_op_s) begin
            res_s = {{HALF{shifted_s[HALF-1]}}, shifted_s[HALF-1:0]};
        end else begin
            res_s = shifted_s;
        end
    end

    // Stage 2 output register, frozen while writeback stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= {XLEN{1'b0}};
            out_tag     <= 5'd0;
            out_illegal <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_result  <= res_s;
                out_tag     <= s1_tag_r;
                out_illegal <= ill_s;
            end
        end
    end
endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vector table, handshake sequences, random vs. model.
module tb_shift_exec_stage;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    shift_exec_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic        hold_chk = 1'b0;
    logic [63:0] held_res;
    logic [4:0]  held_tag;
    logic        held_ill;
    logic        acc;
    vec_t        vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model written from the ISA meaning of each op
    function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [5:0]  s6;
        logic [4:0]  s5;
        logic [31:0] a32;
        logic [31:0] r32;
        logic [63:0] r;
        logic        ill;
        s6 = b[5:0];
        s5 = b[4:0];
        a32 = a[31:0];
        r32 = 32'd0;
        r = 64'd0;
        ill = 1'b0;
        case (op)
            3'b000: r = a << s6;
            3'b001: r = a >> s6;
            3'b010: r = $signed(a) >>> s6;
            3'b100: begin r32 = a32 << s5; r = {{32{r32[31]}}, r32}; end
            3'b101: begin r32 = a32 >> s5; r = {{32{r32[31]}}, r32}; end
            3'b110: begin r32 = $signed(a32) >>> s5; r = {{32{r32[31]}}, r32}; end
`ifdef SHIFT_ROTATE_EN
            3'b011: r = (a << s6) | (a >> (7'd64 - {1'b0, s6}));
            3'b111: r = (a >> s6) | (a << (7'd64 - {1'b0, s6}));
`endif
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    // One clock: drive inputs at the falling edge, check handshakes, then wait for the next falling edge
    task automatic cyc(input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input logic [63:0] er, input logic ei, input logic ordy,
                       output logic accepted);
        exp_t e;
        in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
        #1;
        if (hold_chk) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_result", out_result, held_res);
            chk("hold_tag", {59'd0, out_tag}, {59'd0, held_tag});
            chk("hold_illegal", {63'd0, out_illegal}, {63'd0, held_ill});
        end
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual tag=%0d result=%h expected no output", out_tag, out_result);
            end else begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("illegal", {63'd0, out_illegal}, {63'd0, e.ill});
                chk("tag", {59'd0, out_tag}, {59'd0, e.tag});
            end
        end
        hold_chk = out_valid && !out_ready;
        held_res = out_result;
        held_tag = out_tag;
        held_ill = out_illegal;
        if (accepted) begin
            e.res = er; e.ill = ei; e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic a_unused;
        cyc(1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 64'd0, 1'b0, ordy, a_unused);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] m;
        logic [4:0]  t;
        int          n;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = 64'd0; in_b = 64'd0;
        in_tag = 5'd0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
        chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        // Directed table
        vecs[0]  = '{3'b000, 64'h1, 64'd13, 64'h0000_0000_0000_2000, 1'b0};
        vecs[1]  = '{3'b000, 64'h1, 64'd65, 64'h0000_0000_0000_0002, 1'b0};
        vecs[2]  = '{3'b000, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 1'b0};
        vecs[3]  = '{3'b010, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0};
        vecs[4]  = '{3'b001, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0};
        vecs[5]  = '{3'b101, 64'hFFFF_FFFF_8000_0000, 64'd36, 64'h0000_0000_0800_0000, 1'b0};
        vecs[6]  = '{3'b110, 64'hFFFF_FFFF_8000_0000, 64'd36, 64'hFFFF_FFFF_F800_0000, 1'b0};
        vecs[7]  = '{3'b100, 64'h4000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[8]  = '{3'b010, 64'h8123_4567_89AB_CDEF, 64'd0, 64'h8123_4567_89AB_CDEF, 1'b0};
        vecs[9]  = '{3'b100, 64'h1234_5678_8000_0001, 64'd32, 64'hFFFF_FFFF_8000_0001, 1'b0};
        vecs[10] = '{3'b110, 64'h0000_0000_8000_0000, 64'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[11] = '{3'b001, 64'hDEAD_BEEF_0000_0001, 64'd64, 64'hDEAD_BEEF_0000_0001, 1'b0};
`ifdef SHIFT_ROTATE_EN
        vecs[12] = '{3'b111, 64'h1, 64'd1, 64'h8000_0000_0000_0000, 1'b0};
        vecs[13] = '{3'b011, 64'h8000_0000_0000_0001, 64'd1, 64'h0000_0000_0000_0003, 1'b0};
`else
        vecs[12] = '{3'b111, 64'h1, 64'd1, 64'h0, 1'b1};
        vecs[13] = '{3'b011, 64'h8000_0000_0000_0001, 64'd1, 64'h0, 1'b1};
`endif
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].res, vecs[i].ill, 1'b1, acc);
            chk("table_accept", {63'd0, acc}, 64'd1);
            drain();
        end

        // Latency: visible two cycles after the accepting cycle
        cyc(1'b1, 3'b000, 64'h1, 64'd13, 5'd7, 64'h2000, 1'b0, 1'b1, acc);
        chk("lat_accept", {63'd0, acc}, 64'd1);
        chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
        idle(1'b1);
        chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
        drain();

        // Backpressure: three back-to-back ops with writeback stalled
        cyc(1'b1, 3'b000, 64'h3, 64'd1, 5'd21, 64'h6, 1'b0, 1'b0, acc);
        chk("bp_accept1", {63'd0, acc}, 64'd1);
        cyc(1'b1, 3'b001, 64'h100, 64'd4, 5'd22, 64'h10, 1'b0, 1'b0, acc);
        chk("bp_accept2", {63'd0, acc}, 64'd1);
        cyc(1'b1, 3'b010, 64'hF000_0000_0000_0000, 64'd60, 5'd23, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, acc);
        chk("bp_in_ready_low", {63'd0, acc}, 64'd0);
        cyc(1'b1, 3'b010, 64'hF000_0000_0000_0000, 64'd60, 5'd23, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, acc);
        chk("bp_in_ready_low2", {63'd0, acc}, 64'd0);
        chk("bp_frozen_first", out_result, 64'h6);
        cyc(1'b1, 3'b010, 64'hF000_0000_0000_0000, 64'd60, 5'd23, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, acc);
        chk("bp_accept_on_drain", {63'd0, acc}, 64'd1);
        drain();

        // Asynchronous reset with two ops in flight
        cyc(1'b1, 3'b000, 64'h5, 64'd2, 5'd9, 64'h14, 1'b0, 1'b0, acc);
        cyc(1'b1, 3'b000, 64'h6, 64'd2, 5'd10, 64'h18, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_result", out_result, 64'd0);
        sb.delete();
        hold_chk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("no_stale_valid", {63'd0, out_valid}, 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            op = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            t = 5'($urandom);
            m = ref_model(op, a, b);
            cyc(1'($urandom_range(0, 3) != 0), op, a, b, t, m[63:0], m[64],
                1'($urandom_range(0, 9) < 7), acc);
        end
        n = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
